// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: operation codes, FSM states
// and small decode helpers for the operation field.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     trial;

  assign shifted  = {rem, quo} << 1;
  assign rem_sh   = shifted[2*WIDTH-1:WIDTH];
  assign trial    = {1'b0, rem_sh} - {1'b0, divisor};
  // trial MSB set means the subtraction borrowed: restore and shift in a 0
  assign next_rem = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
  assign next_quo = shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};

endmodule

// File: rtl/iter_div.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with valid/ready handshakes on request and result.
module iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [1:0]       op_reg, op_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;

  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] final_val;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (div_reg),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  assign in_signed = is_signed_op(op);
  assign abs_a     = (in_signed && a[WIDTH-1]) ? (~a + ONE) : a;
  assign abs_b     = (in_signed && b[WIDTH-1]) ? (~b + ONE) : b;

  // Sign correction applied on the last step, from signs latched at acceptance
  assign neg_q     = is_signed_op(op_reg) && (sign_a_reg ^ sign_b_reg);
  assign neg_r     = is_signed_op(op_reg) && sign_a_reg;
  assign final_val = is_rem_op(op_reg)
                   ? (neg_r ? (~step_rem + ONE) : step_rem)
                   : (neg_q ? (~step_quo + ONE) : step_quo);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    div_next    = div_reg;
    result_next = result_reg;
    op_next     = op_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          op_next     = op;
          sign_a_next = a[WIDTH-1];
          sign_b_next = b[WIDTH-1];
          rem_next    = '0;
          quo_next    = abs_a;
          div_next    = abs_b;
          count_next  = '0;
          if (b == '0) begin
            result_next = is_rem_op(op) ? a : '1;
            state_next  = S_DONE;
          end else if (in_signed && (a == MIN_VAL) && (b == '1)) begin
            result_next = is_rem_op(op) ? '0 : a;
            state_next  = S_DONE;
          end else begin
            state_next  = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_next   = step_rem;
        quo_next   = step_quo;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          result_next = final_val;
          state_next  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      div_reg    <= '0;
      result_reg <= '0;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      div_reg    <= div_next;
      result_reg <= result_next;
      op_reg     <= op_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div (WIDTH=32): directed vector table, handshake
// and reset corner sequences, then random operations against an arithmetic model.
module tb_iter_div;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;

  int n_checks = 0;
  int n_fail   = 0;

  iter_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  // Latency is counted in rising edges after the acceptance edge until
  // out_valid is seen: WIDTH for a full division, 0 for special cases
  // (out_valid is already up in the cycle right after acceptance).
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
    case (o)
      2'b00:   return $signed(x) / $signed(y);
      2'b01:   return x / y;
      2'b10:   return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 0;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return W;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble operands after acceptance: they must not be re-sampled
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result, exp);
    $display("%-14s op=%0d a=%08h b=%08h result=%08h lat=%0d", name, o, x, y, result, lat);
    @(posedge clk); #1;
    chk({name, " back_to_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          wait_cnt;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         32, "divu_100_7"};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          32, "remu_100_7"};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, "div_m7_2"};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, "rem_m7_2"};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32, "div_7_m2"};
    vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  "divu_by0"};
    vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          0,  "rem_by0"};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  "div_ovf"};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  "rem_ovf"};
    vecs[9]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32, "remu_big"};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32, "divu_big"};
    vecs[11] = '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32, "div_m7_m2"};
    vecs[12] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32, "rem_m7_m2"};
    vecs[13] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32, "rem_7_m2"};

    // Reset state, asserted from time 0
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("bp latency", 32'(wait_cnt), 32'd32);
    chk("bp result", result, 32'd100);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp result held", result, 32'd100);
    end
    $display("backpressure   held=%08h after 5 stalled cycles", held);
    // Handshake edge with a request pending must not accept it
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    chk("handshake no accept", {30'd0, out_valid, in_ready}, 32'd1);
    in_valid = 1'b0;
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; a = 32'd12345; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("calc in_ready low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst result", result, 32'd0);
    $display("async reset    in_ready=%0d out_valid=%0d", in_ready, out_valid);
    @(negedge clk); rst = 1'b0;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 32);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          mode;
      ro   = 2'($urandom_range(0, 3));
      ra   = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        4:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand_%0d", i), ro, ra, rb, ref_div(ro, ra, rb), ref_lat(ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
